// File: rtl/dmux4way16_buffered_pkg.sv
// dmux4way16_buffered_pkg: lane ids, default width and one-hot lane decode for the 4-way mux/dmux family
package dmux4way16_buffered_pkg;
  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;
  localparam int WIDTH_DEFAULT = 16;
  function automatic logic [3:0] onehot4(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction
endpackage

// File: rtl/dmux4way16_buffered_lane_slot.sv
// lane_slot: one-word lane register with full flag; load/take/reset in, out/full out, load wins over take
module lane_slot
  import dmux4way16_buffered_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             take,
  output logic [WIDTH-1:0] out,
  output logic             full
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             full_d, full_q;
  always_comb begin
    data_d = load ? in : data_q;
    full_d = load | (full_q & ~take);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end
  assign out  = data_q;
  assign full = full_q;
endmodule

// File: rtl/dmux4way16_buffered.sv
// dmux4way16_buffered: valid/ready stream into four buffered lanes a..d (valid, ptr out) by sel or round-robin
module dmux4way16_buffered
  import dmux4way16_buffered_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic             auto,
  input  logic [3:0]       take,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       valid,
  output logic [1:0]       ptr
);
  logic [1:0]       target, ptr_d, ptr_q;
  logic             accept;
  logic [3:0]       load;
  logic [WIDTH-1:0] lane_out [4];
  always_comb begin
    target   = auto ? ptr_q : sel;
    in_ready = ~valid[target] | take[target];
    accept   = in_valid & in_ready & ~reset;
    load     = accept ? onehot4(target) : 4'b0000;
    ptr_d    = (accept & auto) ? ptr_q + 2'd1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 2'd0;
    else ptr_q <= ptr_d;
  end
  for (genvar k = 0; k < 4; k++) begin : g_lane
    lane_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .reset(reset),
      .load (load[k]),
      .in   (in),
      .take (take[k]),
      .out  (lane_out[k]),
      .full (valid[k])
    );
  end
  assign a   = lane_out[LANE_A];
  assign b   = lane_out[LANE_B];
  assign c   = lane_out[LANE_C];
  assign d   = lane_out[LANE_D];
  assign ptr = ptr_q;
endmodule

// File: doc/dmux4way16_buffered.md
Name: dmux4way16_buffered

Overview:
- Receive end of the four-lane 16-bit select path: takes one 16-bit stream and distributes each word to one of four lanes a/b/c/d.
- Each lane holds one word in a register with a full flag until the consumer takes it.
- Lane choice is either addressed by sel or automatic round-robin. A valid/ready handshake on the input stalls the producer while the target lane is occupied.

Parameters:
- WIDTH, 16, data width of the input and of each lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  input data word.
- in_valid  input  1  producer presents a word on in.
- in_ready  output  1  block accepts the word this cycle (combinational).
- sel  input  2  target lane in addressed mode: 0=a, 1=b, 2=c, 3=d.
- auto  input  1  1 = round-robin target from ptr; 0 = target from sel.
- take  input  4  per-lane consume strobe; bit k consumes lane k.
- a, b, c, d  output  WIDTH each  lane holding registers.
- valid  output  4  bit k = lane k holds an untaken word.
- ptr  output  2  round-robin pointer (next auto target).

Behaviour:
- Reset (synchronous, active-high, clk edge with reset=1):
  - a, b, c, d clear to 16'h0000.
  - valid clears to 4'b0000.
  - ptr clears to 2'd0.
  - Any held data is discarded, including reset mid-stream. in and take are ignored that cycle.
  - in_ready follows its normal rule during reset (all lanes empty, so it reads 1), but no accept takes effect.
- Target selection: target = auto ? ptr : sel. This is combinational and re-evaluated every cycle.
- in_ready = ~valid[target] | take[target]. This is pure combinational from valid, take, sel, auto and ptr. It does not depend on in_valid.
- Accept condition: accept = in_valid & in_ready & ~reset.
- On accept:
  - The lane at target loads in. valid[target] is 1 after the edge.
  - Latency is 1 cycle: the word appears on the lane output the cycle after the accept.
  - ptr increments only on accept with auto=1, wrapping 3 to 0. In addressed mode ptr holds its value.
- take[k] with valid[k]=1 clears valid[k] at the edge. The lane data register keeps its old value; it is not cleared.
- take[k] with valid[k]=0 is ignored.
- Accept into lane k and take[k] in the same cycle:
  - The new word is loaded and valid[k] stays 1 (pass-through refill).
  - The old word counts as consumed this cycle.
- Takes on other lanes are independent. Any subset of take bits may be asserted in one cycle.
- Stall: in_valid=1 while the target lane is full and not taken gives in_ready=0.
  - No state changes and ptr does not advance.
  - The producer holds in steady.
- Changing auto or sel while stalled retargets immediately; in_ready is recomputed the same cycle.
- No overflow or loss is possible: a word is either accepted or stalled.

Decomposition:
- Shared constants include (used by the 4-way mux/dmux family): LANE_A=2'd0, LANE_B=2'd1, LANE_C=2'd2, LANE_D=2'd3, and WIDTH_DEFAULT=16.
- One natural sub-module: lane_slot (WIDTH), instantiated 4 times.
  - Inputs: clk, reset, load, in, take.
  - Outputs: out, full.
  - Implements the load/take/simultaneous rules for a single lane.
- Top level holds ptr, the target decode (2-to-4 one-hot), in_ready and the per-lane load = accept & (target==k).

Test Plan:
1. Reset: drive reset=1 for one edge with random in and take -> a=b=c=d=16'h0000, valid=4'b0000, ptr=0. Then check in_ready=1 with auto=1.
2. Addressed fill: auto=0, write 16'h1111/2222/3333/4444 with sel=0..3 -> next cycle a..d hold those values, valid=4'b1111, ptr still 0. Then sel=2, in_valid=1 -> in_ready=0 and c stays 16'h3333.
3. Round-robin wrap: auto=1, take=4'b1111 every cycle, stream 16'hA000..16'hA004 -> lanes a,b,c,d,a receive them in order, ptr goes 1,2,3,0,1. Lane a holds 16'hA004 at the end.
4. Stall and release: all lanes full, auto=1, ptr=0, in=16'hBEEF held -> in_ready=0 and ptr=0. Assert take=4'b0001 -> in_ready=1 that cycle. Next cycle a=16'hBEEF, valid[0]=1, ptr=1.
5. Simultaneous take and refill: lane b full with 16'h0B0B, sel=1, in=16'h0C0C, take=4'b0010 -> b=16'h0C0C and valid[1] stays 1. take=4'b0100 on an empty lane c -> no change.
6. Reset mid-operation: lanes partly full, ptr=2, assert reset together with an accept of 16'hFFFF -> all outputs 0 and ptr=0. The word is not loaded.
